// File: rtl/i2c_pkg.sv
// Shared i2c definitions: response error codes, transaction step encoding
// and sequencer state encoding.
package i2c_pkg;

  localparam logic [1:0] I2C_OK          = 2'd0;
  localparam logic [1:0] I2C_ERR_ADDR    = 2'd1;
  localparam logic [1:0] I2C_ERR_DATA    = 2'd2;
  localparam logic [1:0] I2C_ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    STEP_ADDR_W = 3'd0,
    STEP_REG    = 3'd1,
    STEP_DATA   = 3'd2,
    STEP_STOP   = 3'd3,
    STEP_ADDR_R = 3'd4,
    STEP_NACK   = 3'd5
  } step_e;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_ABORT     = 3'd4,
    S_RSP       = 3'd5
  } state_e;

  // Steps that end a bus transfer only count as done once the bus is released.
  function automatic logic step_releases_bus(input step_e step);
    return (step == STEP_STOP) || (step == STEP_NACK);
  endfunction

endpackage

// File: rtl/i2c_reg_sequencer.sv
// Drives the byte-level i2c controller through complete single-byte register
// write/read transactions, one command in and one response out.
module i2c_reg_sequencer
  import i2c_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_dev_addr,
  input  logic [7:0] cmd_reg_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  output logic       ctl_abort,
  output logic [6:0] ctl_addr,
  output logic       ctl_r_wbar,
  output logic       ctl_send_start,
  output logic [7:0] ctl_data,
  output logic       ctl_write_enable,
  output logic       ctl_read_enable,
  output logic       ctl_send_ack,
  output logic       ctl_send_nack,
  output logic       ctl_send_stop,
  input  logic [7:0] ctl_data_out,
  input  logic       ctl_ack_rx,
  input  logic       ctl_nack_rx,
  input  logic       ctl_ongoing,
  input  logic       ctl_idle
);

  localparam int unsigned    CW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_ZERO = CW'(0);

  state_e      state_q, state_d;
  step_e       step_q, step_d;
  logic [1:0]  err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rw_q, rw_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  wdata_q, wdata_d;

  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic [1:0]  rsp_err_q, rsp_err_d;
  logic        ctl_abort_q, ctl_abort_d;
  logic [6:0]  ctl_addr_q, ctl_addr_d;
  logic        ctl_r_wbar_q, ctl_r_wbar_d;
  logic        ctl_send_start_q, ctl_send_start_d;
  logic [7:0]  ctl_data_q, ctl_data_d;
  logic        ctl_write_enable_q, ctl_write_enable_d;
  logic        ctl_send_nack_q, ctl_send_nack_d;
  logic        ctl_send_stop_q, ctl_send_stop_d;
  logic        issue_s;
  logic        step_done_s;

  // ack_rx is implied by the absence of nack_rx once the controller is idle.
  logic        unused_s;
  assign unused_s    = ctl_ack_rx;
  assign step_done_s = ctl_idle && (!step_releases_bus(step_q) || !ctl_ongoing);

  // Next-state, step evaluation and registered-output next values.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    rw_d    = rw_q;
    dev_d   = dev_q;
    reg_d   = reg_q;
    wdata_d = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          rw_d    = cmd_rw;
          dev_d   = cmd_dev_addr;
          reg_d   = cmd_reg_addr;
          wdata_d = cmd_wdata;
          err_d   = I2C_OK;
          rdata_d = 8'h00;
          step_d  = STEP_ADDR_W;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_ZERO;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        cnt_d = cnt_q + CNT_ONE;
        if (!ctl_idle) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ABORT;
        end else begin
          state_d = S_WAIT_BUSY;
        end
      end
      S_WAIT_DONE: begin
        cnt_d = cnt_q + CNT_ONE;
        if (step_done_s) begin
          state_d = S_ISSUE;
          case (step_q)
            STEP_ADDR_W: begin
              if (ctl_nack_rx) begin
                err_d  = I2C_ERR_ADDR;
                step_d = STEP_STOP;
              end else begin
                step_d = STEP_REG;
              end
            end
            STEP_REG: begin
              if (ctl_nack_rx) begin
                err_d  = I2C_ERR_DATA;
                step_d = STEP_STOP;
              end else if (rw_q) begin
                step_d = STEP_STOP;
              end else begin
                step_d = STEP_DATA;
              end
            end
            STEP_DATA: begin
              if (ctl_nack_rx) begin
                err_d = I2C_ERR_DATA;
              end else begin
                err_d = err_q;
              end
              step_d = STEP_STOP;
            end
            STEP_STOP: begin
              // A clean read continues with a fresh start after the register stop.
              if (rw_q && (err_q == I2C_OK)) begin
                step_d = STEP_ADDR_R;
              end else begin
                state_d = S_RSP;
              end
            end
            STEP_ADDR_R: begin
              if (ctl_nack_rx) begin
                err_d  = I2C_ERR_ADDR;
                step_d = STEP_STOP;
              end else begin
                rdata_d = ctl_data_out;
                step_d  = STEP_NACK;
              end
            end
            STEP_NACK: begin
              state_d = S_RSP;
            end
            default: begin
              err_d   = I2C_ERR_TIMEOUT;
              state_d = S_RSP;
            end
          endcase
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ABORT;
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      S_ABORT: begin
        err_d   = I2C_ERR_TIMEOUT;
        state_d = S_RSP;
      end
      S_RSP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    issue_s            = (state_d == S_ISSUE);
    cmd_ready_d        = (state_d == S_IDLE);
    rsp_valid_d        = (state_d == S_RSP);
    rsp_err_d          = rsp_valid_d ? err_d : I2C_OK;
    rsp_rdata_d        = (rsp_valid_d && (err_d == I2C_OK)) ? rdata_d : 8'h00;
    ctl_abort_d        = (state_d == S_ABORT);
    ctl_addr_d         = dev_d;
    ctl_send_start_d   = issue_s && ((step_d == STEP_ADDR_W) || (step_d == STEP_ADDR_R));
    ctl_write_enable_d = issue_s && ((step_d == STEP_REG) || (step_d == STEP_DATA));
    ctl_send_stop_d    = issue_s && (step_d == STEP_STOP);
    ctl_send_nack_d    = issue_s && (step_d == STEP_NACK);

    if (issue_s) begin
      ctl_r_wbar_d = (step_d == STEP_ADDR_R);
    end else begin
      ctl_r_wbar_d = ctl_r_wbar_q;
    end

    // Data stays put between pulses so the controller can sample it late.
    if (issue_s && (step_d == STEP_REG)) begin
      ctl_data_d = reg_d;
    end else if (issue_s && (step_d == STEP_DATA)) begin
      ctl_data_d = wdata_d;
    end else begin
      ctl_data_d = ctl_data_q;
    end
  end

  // State, latched command fields and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= S_IDLE;
      step_q             <= STEP_ADDR_W;
      err_q              <= I2C_OK;
      cnt_q              <= CNT_ZERO;
      rdata_q            <= 8'h00;
      rw_q               <= 1'b0;
      dev_q              <= 7'h00;
      reg_q              <= 8'h00;
      wdata_q            <= 8'h00;
      cmd_ready_q        <= 1'b1;
      rsp_valid_q        <= 1'b0;
      rsp_rdata_q        <= 8'h00;
      rsp_err_q          <= I2C_OK;
      ctl_abort_q        <= 1'b0;
      ctl_addr_q         <= 7'h00;
      ctl_r_wbar_q       <= 1'b0;
      ctl_send_start_q   <= 1'b0;
      ctl_data_q         <= 8'h00;
      ctl_write_enable_q <= 1'b0;
      ctl_send_nack_q    <= 1'b0;
      ctl_send_stop_q    <= 1'b0;
    end else begin
      state_q            <= state_d;
      step_q             <= step_d;
      err_q              <= err_d;
      cnt_q              <= cnt_d;
      rdata_q            <= rdata_d;
      rw_q               <= rw_d;
      dev_q              <= dev_d;
      reg_q              <= reg_d;
      wdata_q            <= wdata_d;
      cmd_ready_q        <= cmd_ready_d;
      rsp_valid_q        <= rsp_valid_d;
      rsp_rdata_q        <= rsp_rdata_d;
      rsp_err_q          <= rsp_err_d;
      ctl_abort_q        <= ctl_abort_d;
      ctl_addr_q         <= ctl_addr_d;
      ctl_r_wbar_q       <= ctl_r_wbar_d;
      ctl_send_start_q   <= ctl_send_start_d;
      ctl_data_q         <= ctl_data_d;
      ctl_write_enable_q <= ctl_write_enable_d;
      ctl_send_nack_q    <= ctl_send_nack_d;
      ctl_send_stop_q    <= ctl_send_stop_d;
    end
  end

  assign cmd_ready        = cmd_ready_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_rdata        = rsp_rdata_q;
  assign rsp_err          = rsp_err_q;
  assign ctl_abort        = ctl_abort_q;
  assign ctl_addr         = ctl_addr_q;
  assign ctl_r_wbar       = ctl_r_wbar_q;
  assign ctl_send_start   = ctl_send_start_q;
  assign ctl_data         = ctl_data_q;
  assign ctl_write_enable = ctl_write_enable_q;
  assign ctl_send_nack    = ctl_send_nack_q;
  assign ctl_send_stop    = ctl_send_stop_q;
  assign ctl_read_enable  = 1'b0;
  assign ctl_send_ack     = 1'b0;

endmodule
